// File: rtl/guitar_fx_pkg.sv
// Shared types and constants for the guitar effects datapath.
//   dl_state_e  : delay-line control FSM states
//   DlLatency   : edges from sample acceptance to registered output
package guitar_fx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StOut
  } dl_state_e;

  localparam int unsigned DlLatency = 2;

endpackage

// File: rtl/dp_ram_sync.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
//   CLK   : clock, rising edge
//   WE    : write enable for port 1
//   ADDR1 : write address
//   DI    : write data
//   ADDR2 : read address
//   DO2   : read data, valid one cycle after ADDR2 is presented
module dp_ram_sync #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] DI,
  input  logic [ADDR_WIDTH-1:0] ADDR2,
  output logic [DATA_WIDTH-1:0] DO2
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  // Read returns the old contents on a same-address write.
  always_ff @(posedge CLK) begin
    if (WE) begin
      mem[ADDR1] <= DI;
    end
    DO2 <= mem[ADDR2];
  end

endmodule

// File: rtl/delay_line.sv
// Circular-buffer delay line: each accepted sample is stored and the sample
// taken DELAY samples earlier is returned two edges later.
//   CLK       : clock, rising edge
//   RST_N     : synchronous active-low reset
//   IN_VALID  : sample present on DIN
//   IN_READY  : sample can be accepted this cycle
//   DIN       : input sample
//   DELAY     : delay in samples, captured on acceptance
//   CLEAR     : flush history (honoured only while idle)
//   DOUT      : delayed sample, registered
//   OUT_VALID : one-cycle pulse qualifying DOUT
module delay_line
  import guitar_fx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic [ADDR_WIDTH-1:0] DELAY,
  input  logic                  CLEAR,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  OUT_VALID
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] FillMax = ADDR_WIDTH'(DEPTH - 1);

  dl_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] dly_q, dly_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  ram_we;

  assign IN_READY  = (state_q == StIdle) && !CLEAR;
  assign DOUT      = dout_q;
  assign OUT_VALID = out_valid_q;

  // Gated by RST_N so a reset landing in StOut aborts the write.
  assign ram_we = (state_q == StOut) && RST_N;

  dp_ram_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .CLK   (CLK),
    .WE    (ram_we),
    .ADDR1 (wr_ptr_q),
    .DI    (din_q),
    .ADDR2 (rd_addr_q),
    .DO2   (ram_rdata)
  );

  // fill_q counts samples written before the current one; stale RAM
  // contents beyond it read as silence.
  always_comb begin
    sel_data = '0;
    if (dly_q == '0) begin
      sel_data = din_q;
    end else if (fill_q >= dly_q) begin
      sel_data = ram_rdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    dly_d       = dly_q;
    rd_addr_d   = rd_addr_q;
    din_d       = din_q;
    dout_d      = dout_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (CLEAR) begin
          wr_ptr_d = '0;
          fill_d   = '0;
        end else if (IN_VALID) begin
          din_d     = DIN;
          dly_d     = DELAY;
          rd_addr_d = wr_ptr_q - DELAY;
          state_d   = StRd;
        end
      end
      StRd: begin
        state_d = StOut;
      end
      StOut: begin
        wr_ptr_d    = wr_ptr_q + 1'b1;
        fill_d      = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
        dout_d      = sel_data;
        out_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      dly_q       <= '0;
      rd_addr_q   <= '0;
      din_q       <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      dly_q       <= dly_d;
      rd_addr_q   <= rd_addr_d;
      din_q       <= din_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_delay_line.sv
module tb_delay_line;

  localparam time Period = 10;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        CLEAR = 1'b0;
  logic [31:0] DIN = '0;
  logic [2:0]  DELAY = '0;
  logic        IN_READY;
  logic        OUT_VALID;
  logic [31:0] DOUT;

  delay_line #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (3)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .DIN       (DIN),
    .DELAY     (DELAY),
    .CLEAR     (CLEAR),
    .DOUT      (DOUT),
    .OUT_VALID (OUT_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    time         t;
  } exp_t;

  typedef struct {
    bit          clr;
    bit          hold;
    logic [31:0] din;
    logic [2:0]  dly;
    logic [31:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, req);
    end
  endtask

  // Every OUT_VALID pulse must match the next queued expectation in data and time.
  always @(posedge CLK) begin
    #1;
    if (OUT_VALID === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid at %0t: got DOUT=%0d, required no pulse", $time, DOUT);
      end else begin
        mon_e = sb.pop_front();
        check("dout", DOUT, mon_e.data);
        check("out_time", 32'($time - 1), 32'(mon_e.t));
      end
    end
  end

  // Called just after a negedge; returns just after a negedge.
  task automatic send(input logic [31:0] d, input logic [2:0] dl, input logic [31:0] e,
                      input bit hold, input bit push, output time t_acc);
    int n = 0;
    IN_VALID = 1'b1;
    DIN      = d;
    DELAY    = dl;
    #4;
    while (IN_READY !== 1'b1 && n < 20) begin
      @(negedge CLK);
      #4;
      n++;
    end
    t_acc = 0;
    if (IN_READY !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout din=%0d: got IN_READY=0, required 1", d);
      IN_VALID = 1'b0;
      @(negedge CLK);
    end else begin
      @(posedge CLK);
      t_acc = $time;
      if (push) sb.push_back('{data: e, t: $time + 2 * Period});
      @(negedge CLK);
      if (!hold) IN_VALID = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic pulse_clear();
    IN_VALID = 1'b0;
    CLEAR    = 1'b1;
    #4;
    check("ready_low_on_clear", {31'b0, IN_READY}, 32'd0);
    @(negedge CLK);
    CLEAR = 1'b0;
  endtask

  initial begin
    time t;
    time prev_t;
    bit  prev_hold;
    bit  hold;

    // Reset and idle
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_dout", DOUT, 32'd0);
    check("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    check("rst_in_ready", {31'b0, IN_READY}, 32'd1);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    check("idle_out_valid", {31'b0, OUT_VALID}, 32'd0);

    // Pass-through
    tbl.push_back('{clr: 0, hold: 0, din: 10, dly: 0, exp: 10});
    tbl.push_back('{clr: 0, hold: 0, din: 20, dly: 0, exp: 20});
    tbl.push_back('{clr: 0, hold: 0, din: 30, dly: 0, exp: 30});
    // Delay 3, priming zeros
    for (int k = 1; k <= 8; k++)
      tbl.push_back('{clr: (k == 1), hold: 0, din: k, dly: 3, exp: (k > 3) ? k - 3 : 0});
    // Delay 7 with wrap, IN_VALID held high
    for (int k = 1; k <= 12; k++)
      tbl.push_back('{clr: (k == 1), hold: 1, din: k, dly: 7, exp: (k > 7) ? k - 7 : 0});
    // Delay 2 before a flush
    for (int k = 1; k <= 5; k++)
      tbl.push_back('{clr: (k == 1), hold: 0, din: k, dly: 2, exp: (k > 2) ? k - 2 : 0});

    prev_t    = 0;
    prev_hold = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].clr) begin
        drain();
        pulse_clear();
      end
      hold = tbl[i].hold && (i + 1 < tbl.size()) && tbl[i + 1].hold;
      send(tbl[i].din, tbl[i].dly, tbl[i].exp, hold, 1'b1, t);
      if (tbl[i].hold && prev_hold) check("accept_spacing", 32'(t - prev_t), 32'(3 * Period));
      prev_t    = t;
      prev_hold = tbl[i].hold;
    end
    drain();

    // CLEAR together with IN_VALID: flush wins, sample dropped
    IN_VALID = 1'b1;
    DIN      = 32'd999;
    DELAY    = 3'd2;
    CLEAR    = 1'b1;
    #4;
    check("ready_low_clear_valid", {31'b0, IN_READY}, 32'd0);
    @(negedge CLK);
    CLEAR    = 1'b0;
    IN_VALID = 1'b0;
    send(32'd100, 3'd2, 32'd0, 1'b0, 1'b1, t);
    send(32'd101, 3'd2, 32'd0, 1'b0, 1'b1, t);
    send(32'd102, 3'd2, 32'd100, 1'b0, 1'b1, t);
    drain();
    repeat (4) @(negedge CLK);

    // Reset while in RD aborts the sample
    send(32'd55, 3'd1, 32'd0, 1'b0, 1'b0, t);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    check("rd_rst_dout", DOUT, 32'd0);
    check("rd_rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    check("rd_rst_in_ready", {31'b0, IN_READY}, 32'd1);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    send(32'd7, 3'd1, 32'd0, 1'b0, 1'b1, t);
    send(32'd8, 3'd1, 32'd7, 1'b0, 1'b1, t);
    drain();
    repeat (4) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
